// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instruction_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_W          = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // One prefetch buffer slot: the fetched word tagged with its byte address.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_instr_mem.sv
// Instruction memory: synchronous read, read-first on a same-word write.
// Contents are never reset so a loaded program survives a core reset.
module instr_mem
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Read samples the pre-write contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, issue control, one-deep in-flight tracking and a small
// prefetch FIFO presenting instructions over a valid/ready handshake.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  input  logic                          instr_ready,
  output logic                          instr_valid,
  output logic [INSTR_W-1:0]            instruction,
  output logic [31:0]                   instr_pc,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [INSTR_W-1:0]            imem_wdata
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]        fetch_pc;
  logic [31:0]        issue_pc;
  logic               inflight_valid;
  logic [31:0]        inflight_pc;
  logic [CW-1:0]      count;
  logic [CW-1:0]      occupancy;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [INSTR_W-1:0] mem_rdata;
  logic               pop;
  logic               push;
  logic               issue;
  fetch_entry_t       fifo_mem [FIFO_DEPTH];
  fetch_entry_t       head;

  // The memory read port follows issue_pc every cycle; the result is only
  // kept when that cycle actually issued (tracked by inflight_valid).
  instr_mem #(
    .DEPTH (IMEM_DEPTH)
  ) u_instr_mem (
    .clk   (clk),
    .raddr (issue_pc[AW+1:2]),
    .rdata (mem_rdata),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata)
  );

  assign instr_valid = (count != '0);
  assign head        = fifo_mem[rd_ptr];

  // Issue decision: a redirect always issues; otherwise only when the FIFO
  // is guaranteed room for the word once it returns.
  always_comb begin
    pop       = instr_valid && instr_ready;
    occupancy = count + CW'(inflight_valid) - CW'(pop);
    issue_pc  = redirect_valid ? (redirect_pc & ~32'd3) : fetch_pc;
    issue     = redirect_valid || (occupancy < CW'(FIFO_DEPTH));
    push      = inflight_valid && !redirect_valid;
  end

  // PC, in-flight tag and FIFO bookkeeping; a redirect empties the FIFO
  // after its own pop and drops the read issued in the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc       <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
      count          <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
    end else begin
      inflight_valid <= issue;
      if (issue) begin
        inflight_pc <= issue_pc;
        fetch_pc    <= issue_pc + 32'd4;
      end
      if (redirect_valid) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // FIFO storage needs no reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem[wr_ptr] <= '{pc: inflight_pc, instr: mem_rdata};
    end
  end

  // Head of FIFO, forced to zero when nothing is buffered.
  always_comb begin
    instruction = NOP_INSTR;
    instr_pc    = '0;
    if (instr_valid) begin
      instruction = head.instr;
      instr_pc    = head.pc;
    end
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

- Front-end stage that feeds the single-cycle processor its `instruction` word each cycle.
- Holds the program counter, an internal synchronous-read instruction memory (`instr_mem`) and a small prefetch FIFO.
- Presents instructions downstream over a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes all buffered and in-flight fetches.

## Interface
Parameters:
- `IMEM_DEPTH`, 256 — instruction memory size in 32-bit words; power of two.
- `FIFO_DEPTH`, 2 — prefetch buffer entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000 — PC loaded on reset.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `redirect_valid` in 1 — load a new PC this cycle and flush.
- `redirect_pc` in 32 — redirect target; bits [1:0] ignored (treated as 0).
- `instr_ready` in 1 — downstream accepts the head instruction.
- `instr_valid` out 1 — `instruction`/`instr_pc` hold a valid entry.
- `instruction` out 32 — fetched word; feeds the processor's `instruction` input.
- `instr_pc` out 32 — byte address of `instruction`.
- `imem_we` in 1 — program-load write enable.
- `imem_waddr` in log2(IMEM_DEPTH) — word address for the load write.
- `imem_wdata` in 32 — load data.

## Operation
- **Word index:** `pc[log2(IMEM_DEPTH)+1:2]`. Upper PC bits are ignored, so addressing wraps modulo IMEM_DEPTH words.
- **Issue rule:** a fetch issues in a cycle when `count + inflight - pop < FIFO_DEPTH`, or when `redirect_valid` is high.
  - `pop` = `instr_valid && instr_ready`.
  - On issue, `fetch_pc <= issue_pc + 4`.
- **Issue address:** `issue_pc` is `redirect_pc & ~3` when `redirect_valid`, otherwise `fetch_pc`.
- **Memory read:** synchronous. Data for an address issued in cycle N is returned in cycle N+1. The returned data, tagged with its PC, is pushed into the FIFO at the end of N+1, unless it was flushed.
- **Redirect in cycle R:**
  - A pop in cycle R still completes; the consumer owns that word.
  - All remaining FIFO entries are discarded.
  - The single in-flight read (issued R-1) is dropped.
  - `redirect_pc` is issued in cycle R.
- **Memory write:** `imem_we` writes `imem_wdata` at the end of the cycle. A same-cycle read of the same word returns the old data (read-first). Writes are allowed at any time; no coherence with already-buffered entries.
- **Outputs:** head of FIFO. When empty, `instr_valid` = 0 and `instruction`/`instr_pc` are driven 0.
- **Reset:**
  - `fetch_pc <= RESET_PC`; FIFO emptied; in-flight cleared.
  - `instr_valid` = 0, `instruction` = 0, `instr_pc` = 0.
  - Memory contents are not cleared.
  - Reset mid-operation discards everything, same as reset from power-up.
- **Simultaneous redirect and rst:** `rst` wins.

## Timing
- Cycle 0 is the first cycle with `rst` low. Cycle 0 issues `RESET_PC`; `instr_valid` = 1 from cycle 2.
- **Fetch latency:** 2 cycles from issue to `instr_valid`.
- **Redirect latency:** redirect in cycle R gives the target visible in R+2. `instr_valid` is 0 in R+1; it is also 0 in R+2 only if the target read is lost to a later redirect.
- **Throughput:** sustained 1 instruction/cycle with `instr_ready` held high (FIFO_DEPTH=2).
- **Backpressure:** with `instr_ready` low, the FIFO fills and issue stops. Head outputs are held stable until popped; no entry is lost or duplicated.
- **Redirect on consecutive cycles:** only the last target survives.
- **Wrap-around:** PC `(IMEM_DEPTH-1)*4` is followed by `IMEM_DEPTH*4`, which reads word 0; `instr_pc` reports the full 32-bit PC.

## Structure
- **Shared package:**
  - `RESET_PC_DEFAULT`.
  - `INSTR_W` = 32.
  - `NOP_INSTR` = 32'h0000_0000.
  - Typedef for a FIFO entry {pc, instr}.
- **Sub-module `instr_mem`:** synchronous read-first single-port-read/single-port-write RAM, parameterised by depth.
- PC, issue logic, in-flight tracking and FIFO stay in `instruction_fetch`.

## Test plan
- **Reset and sequential fetch.** Stimulus: load words 0..3 with 32'h2001_0005, 32'h2002_0003, 32'h0022_1820, 32'hAC03_0000; deassert `rst`; `instr_ready`=1. Required: cycles 2..5 show those words with `instr_pc` 0, 4, 8, 12; no bubbles.
- **Backpressure.** Stimulus: hold `instr_ready`=0 for cycles 2..6, then release. Required: 32'h2001_0005/pc 0 held stable; then pcs 4, 8 in order with none skipped or repeated.
- **Redirect.** Stimulus: redirect to 32'h0000_0042 in cycle 4 while popping. Required: pop in cycle 4 completes; `instr_valid`=0 in cycle 5; cycle 6 shows `instr_pc`=32'h40 (low bits dropped) with word 16.
- **Back-to-back redirects, and rst+redirect in the same cycle.** Stimulus: redirect to 32'h80 then 32'hC0 on consecutive cycles; separately, assert `rst` and redirect together. Required: only pc 32'hC0 appears; for the `rst`+redirect case, restart from `RESET_PC`.
- **Wrap-around.** Stimulus: `IMEM_DEPTH`=256; redirect to 32'h3FC. Required: pc 32'h3FC then 32'h400, the latter returning word 0.
- **Write/read collision.** Stimulus: write word 5 in the same cycle pc 20 is issued. Required: old value returned; a refetch after redirect to 20 returns the new value.
